// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
//
// Purpose: holds the FSM state enumeration and the default operand width
//          shared by serial_adder and its bench.
// Contents:
//   DEFAULT_WIDTH - default operand/result width in bits
//   state_e       - IDLE / RUN / DONE controller states
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - single-bit combinational full adder
//
// Purpose: per-cycle bit arithmetic for the bit-serial adder.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out (majority of a, b, cin)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one bit per clock
//
// Purpose: adds two WIDTH-bit operands over WIDTH RUN cycles and presents
//          the result with a one-cycle done pulse.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - begin an addition, sampled only in IDLE
//   a, b  - operands, captured on the edge that accepts start
//   busy  - high while in RUN
//   done  - one-cycle pulse, sum/cout valid
//   sum   - (a+b) mod 2^WIDTH, held until the next completed addition
//   cout  - carry out of bit WIDTH-1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_s, fa_c;

  full_adder_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    c_d     = c_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = fa_c;
        // Each new bit enters at the MSB, so after WIDTH shifts bit 0 sits at index 0.
        res_d  = {fa_s, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          // Visible outputs change only here; during RUN they keep the previous result.
          sum_d   = res_d;
          cout_d  = fa_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_sum = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle
  // again, so consecutive calls issue start in the cycle right after the done cycle.
  // inject_at: edge number (relative to the accepting edge 0) at which a stray
  // start with other operands is presented; -1 for none.
  task automatic run_add(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] exp_sum, input logic exp_cout, input int inject_at);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= W; j++) begin
      // Now sitting after edge j.
      if (j < W) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s run edge %0d: busy=%b done=%b expected busy=1 done=0", name, j, busy, done);
        end
        checks++;
        if (sum !== prev_sum) begin
          errors++;
          $display("FAIL %s hold during run edge %0d: sum=%h expected %h", name, j, sum, prev_sum);
        end
      end else begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
          errors++;
          $display("FAIL %s done cycle: busy=%b done=%b expected busy=0 done=1", name, busy, done);
        end
        checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
          errors++;
          $display("FAIL %s result: sum=%h cout=%b expected sum=%h cout=%b", name, sum, cout, exp_sum, exp_cout);
        end
      end
      // Operands are perturbed after acceptance; the result must not care.
      a = ~a + 8'd3;
      b = b ^ 8'hA5;
      if (j == inject_at - 1) begin
        start = 1'b1;
        a = 8'h55;
        b = 8'h11;
      end else begin
        start = 1'b0;
      end
      if (j < W) @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== exp_sum || cout !== exp_cout) begin
      errors++;
      $display("FAIL %s after done: busy=%b done=%b sum=%h cout=%b expected 0 0 %h %b",
               name, busy, done, sum, cout, exp_sum, exp_cout);
    end
    prev_sum = exp_sum;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: busy=%b done=%b expected 0 0", busy, done);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset result: sum=%h cout=%b expected 00 0", sum, cout);
    end
  endtask

  task automatic test_basic();
    // Start presented on the very first edge with rst low.
    rst = 1'b0;
    run_add("basic_0F_01", 8'h0F, 8'h01, 8'h10, 1'b0, -1);
  endtask

  task automatic test_overflow();
    run_add("ovf_FF_01", 8'hFF, 8'h01, 8'h00, 1'b1, -1);
    run_add("ovf_FF_FF", 8'hFF, 8'hFF, 8'hFE, 1'b1, -1);
  endtask

  task automatic test_ignore_start();
    run_add("ignore_run", 8'h0F, 8'h01, 8'h10, 1'b0, 3);
    run_add("ignore_done", 8'h3C, 8'h0A, 8'h46, 1'b0, W + 1);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    start = 1'b1;
    a = 8'h0F;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0",
               busy, done, sum, cout);
    end
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_mid abandoned: busy/done cycles=%0d expected 0", done_seen);
    end
    prev_sum = 8'h00;
    run_add("after_reset_23_45", 8'h23, 8'h45, 8'h68, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    run_add("b2b_first_80_80", 8'h80, 8'h80, 8'h00, 1'b1, -1);
    run_add("b2b_second_64_64", 8'h64, 8'h64, 8'hC8, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
